// File: rtl/framebuffer_port_arbiter.sv
// framebuffer_port_arbiter
// Shares one single-port 16-bit framebuffer RAM between a byte-wide writer
// and a 16-bit pixel reader. Reads win arbitration. Writes wait in a small
// FIFO and drain in cycles with no read. A starvation counter forces a
// write slot when writes have been pending for too long.
module framebuffer_port_arbiter #(
  parameter int ADDR_WIDTH      = 12,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int STARVE_LIMIT    = 4,
  parameter int STARVE_WIDTH    = 3
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       wr_req,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ready,
  input  logic                       rd_req,
  input  logic [ADDR_WIDTH-2:0]      rd_addr,
  output logic                       rd_grant,
  output logic                       rd_valid,
  output logic [15:0]                rd_data,
  output logic [ADDR_WIDTH-2:0]      mem_addr,
  output logic [15:0]                mem_wdata,
  output logic [1:0]                 mem_be,
  output logic                       mem_we,
  output logic                       mem_ce,
  input  logic [15:0]                mem_rdata,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       overflow,
  output logic [7:0]                 writes_committed
);

  localparam int                       DEPTH      = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [STARVE_WIDTH-1:0]  STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

  // Per-cycle owner of the RAM port.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ,
    ARB_WRITE,
    ARB_FORCE_WR
  } arb_e;

  // Write FIFO storage and bookkeeping.
  logic [ADDR_WIDTH-1:0]      r_fifo_addr [DEPTH];
  logic [7:0]                 r_fifo_data [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_level;
  logic                       r_wr_ready;
  logic                       r_overflow;
  logic [7:0]                 r_commit_cnt;
  logic [STARVE_WIDTH-1:0]    r_starve_cnt;

  // Read return pipeline: grant -> RAM data -> registered output.
  logic                       r_rd_pend;
  logic                       r_rd_valid;
  logic [15:0]                r_rd_data;

  arb_e                       w_arb;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic [FIFO_DEPTH_LOG2:0]   w_level_next;
  logic [ADDR_WIDTH-1:0]      w_head_addr;
  logic [7:0]                 w_head_data;

  assign w_empty     = (r_level == '0);
  assign w_push      = wr_req && r_wr_ready;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Arbitration: starvation override, then reads, then queued writes.
  // An asserted reset holds the port idle so nothing reaches the RAM.
  always_comb begin
    w_arb = ARB_IDLE;
    if (reset) begin
      w_arb = ARB_IDLE;
    end else if ((r_starve_cnt == STARVE_MAX) && !w_empty) begin
      w_arb = ARB_FORCE_WR;
    end else if (rd_req) begin
      w_arb = ARB_READ;
    end else if (!w_empty) begin
      w_arb = ARB_WRITE;
    end
  end

  assign w_pop = (w_arb == ARB_WRITE) || (w_arb == ARB_FORCE_WR);

  // Drive the RAM port from the decision and the registered FIFO head.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    rd_grant  = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_arb)
      ARB_READ: begin
        rd_grant = 1'b1;
        mem_ce   = 1'b1;
        mem_addr = rd_addr;
      end
      ARB_WRITE, ARB_FORCE_WR: begin
        mem_ce   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = w_head_addr[ADDR_WIDTH-1:1];
        if (w_head_addr[0]) begin
          mem_be    = 2'b01;
          mem_wdata = {8'h00, w_head_data};
        end else begin
          mem_be    = 2'b10;
          mem_wdata = {w_head_data, 8'h00};
        end
      end
      default: ;
    endcase
  end

  // Next FIFO occupancy; a simultaneous push and pop leave it unchanged.
  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + (FIFO_DEPTH_LOG2 + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_level_next = r_level - (FIFO_DEPTH_LOG2 + 1)'(1);
    end
  end

  // FIFO payload store.
  // NOTE: the storage array has no reset; the pointers and level decide
  // which entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, level, ready flag and sticky overflow.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_wr_ready <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
      r_level    <= w_level_next;
      r_wr_ready <= (w_level_next != LEVEL_FULL);
      if (wr_req && !r_wr_ready) r_overflow <= 1'b1;
    end
  end

  // Starvation counter and committed-write counter.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_commit_cnt <= '0;
    end else begin
      if (w_pop || w_empty) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != STARVE_MAX) begin
        r_starve_cnt <= r_starve_cnt + STARVE_WIDTH'(1);
      end
      if (w_pop) r_commit_cnt <= r_commit_cnt + 8'd1;
    end
  end

  // Read return: capture RAM data the cycle after a grant, strobe valid.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend  <= rd_grant;
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= mem_rdata;
    end
  end

  assign wr_ready         = r_wr_ready;
  assign fifo_level       = r_level;
  assign overflow         = r_overflow;
  assign writes_committed = r_commit_cnt;
  assign rd_valid         = r_rd_valid;
  assign rd_data          = r_rd_data;

endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// Self-checking bench for framebuffer_port_arbiter. A behavioural RAM sits
// on the mem_* port; a monitor scoreboards every RAM write against the
// pushes that produced it and every read return against its grant.
module tb_framebuffer_port_arbiter;

  localparam int AW = 12;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic [AW-2:0] rd_addr;
  logic          rd_grant;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic [AW-2:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_be;
  logic          mem_we;
  logic          mem_ce;
  logic [15:0]   mem_rdata;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic [7:0]    writes_committed;

  framebuffer_port_arbiter #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH_LOG2(2), .STARVE_LIMIT(4), .STARVE_WIDTH(3)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_ce(mem_ce), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .overflow(overflow),
    .writes_committed(writes_committed)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [1:0]    be;
    logic [15:0]   wdata;
  } wr_exp_t;

  typedef struct packed {
    logic [15:0] data;
    int          due;
  } rd_exp_t;

  wr_exp_t     wr_q[$];
  rd_exp_t     rd_q[$];
  int          cycle = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] ram [0:2047];

  always @(posedge clk_in) cycle <= cycle + 1;

  // Behavioural single-port RAM: byte-enabled writes, one-cycle read data.
  always @(posedge clk_in) begin
    if (mem_ce && mem_we) begin
      if (mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
      if (mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
    end
    if (mem_ce && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (wr_req && wr_ready) begin
        wr_exp_t e;
        e.addr  = wr_addr[AW-1:1];
        e.be    = wr_addr[0] ? 2'b01 : 2'b10;
        e.wdata = wr_addr[0] ? {8'h00, wr_data} : {wr_data, 8'h00};
        wr_q.push_back(e);
      end
      if (mem_we) begin
        n_checks++;
        if (!mem_ce || wr_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_write: unexpected write ce=%b addr=%h queued=%0d", mem_ce, mem_addr, wr_q.size());
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          if ({mem_addr, mem_be, mem_wdata} !== {e.addr, e.be, e.wdata}) begin
            n_errors++;
            $display("FAIL sb_write: got addr=%h be=%b wdata=%h expected addr=%h be=%b wdata=%h",
                     mem_addr, mem_be, mem_wdata, e.addr, e.be, e.wdata);
          end
        end
      end
      if (rd_q.size() > 0 && rd_q[0].due == cycle) begin
        rd_exp_t e;
        e = rd_q.pop_front();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== e.data) begin
          n_errors++;
          $display("FAIL sb_read: got valid=%b data=%h expected valid=1 data=%h", rd_valid, rd_data, e.data);
        end
      end else if (rd_valid !== 1'b0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_read: got unexpected rd_valid=%b expected 0", rd_valid);
      end
      if (rd_grant) begin
        rd_exp_t e;
        n_checks++;
        if (mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== rd_addr) begin
          n_errors++;
          $display("FAIL sb_grant: got ce=%b we=%b addr=%h expected ce=1 we=0 addr=%h", mem_ce, mem_we, mem_addr, rd_addr);
        end
        e.data = ram[rd_addr];
        e.due  = cycle + 2;
        rd_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_values(input string name);
    logic [61:0] got;
    logic [61:0] exp;
    got = {rd_grant, rd_valid, rd_data, mem_ce, mem_we, mem_be, mem_addr, mem_wdata,
           fifo_level, wr_ready, overflow, writes_committed};
    exp = {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 11'h0, 16'h0, 3'd0, 1'b1, 1'b0, 8'h0};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    rd_req = 1'b1;
    rd_addr = 11'h010;
    repeat (3) tick();
    @(negedge clk_in);
    check_reset_values("reset_state");
    tick();
    reset  = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic test_write_lane();
    wr_req = 1'b1; wr_addr = 12'h0A5; wr_data = 8'h3C; rd_req = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL write_no_bypass: got we=%b ready=%b expected we=0 ready=1", mem_we, wr_ready);
    end
    tick();
    wr_req = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if ({mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 11'h052, 2'b01, 16'h003C}) begin
      n_errors++;
      $display("FAIL write_lane: got we=%b addr=%h be=%b wdata=%h expected we=1 addr=052 be=01 wdata=003c",
               mem_we, mem_addr, mem_be, mem_wdata);
    end
    tick();
    @(negedge clk_in);
    n_checks++;
    if (writes_committed !== 8'd1 || fifo_level !== 3'd0) begin
      n_errors++;
      $display("FAIL write_count: got committed=%0d level=%0d expected committed=1 level=0", writes_committed, fifo_level);
    end
    tick();
  endtask

  task automatic test_read();
    rd_req = 1'b1; rd_addr = 11'h010;
    @(negedge clk_in);
    n_checks++;
    if (rd_grant !== 1'b1) begin
      n_errors++;
      $display("FAIL read_grant: got %b expected 1", rd_grant);
    end
    tick();
    rd_req = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL read_early: got rd_valid=%b expected 0", rd_valid);
    end
    tick();
    @(negedge clk_in);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL read_data: got valid=%b data=%h expected valid=1 data=beef", rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_words [3];
    exp_words[0] = 16'h1111; exp_words[1] = 16'h2222; exp_words[2] = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      rd_req  = (i < 3);
      rd_addr = 11'h020 + 11'(i);
      @(negedge clk_in);
      if (i >= 2) begin
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_words[i-2]) begin
          n_errors++;
          $display("FAIL back_to_back[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                   i - 2, rd_valid, rd_data, exp_words[i-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    rd_req = 1'b1; rd_addr = 11'h030;
    wr_req = 1'b1; wr_addr = 12'h100; wr_data = 8'h77;
    tick();
    wr_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      n_checks++;
      if (rd_grant !== (k != 5) || mem_we !== (k == 5)) begin
        n_errors++;
        $display("FAIL starve_cycle%0d: got grant=%b we=%b expected grant=%b we=%b",
                 k, rd_grant, mem_we, (k != 5), (k == 5));
      end
      tick();
    end
    rd_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    int budget;
    rd_req = 1'b1; rd_addr = 11'h031;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_addr = 12'h200 + 12'(i); wr_data = 8'hA0 + 8'(i);
      @(negedge clk_in);
      if (i == 4) begin
        n_checks++;
        if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL fifo_full: got level=%0d ready=%b expected level=4 ready=0", fifo_level, wr_ready);
        end
      end
      tick();
    end
    wr_req = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_set: got %b expected 1", overflow);
    end
    tick();
    rd_req = 1'b0;
    budget = 20;
    while (fifo_level !== 3'd0 && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_errors++;
      $display("FAIL drain_timeout: got level=%0d expected 0", fifo_level);
    end
    repeat (3) tick();
    @(negedge clk_in);
    n_checks++;
    if (overflow !== 1'b1 || wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_sticky: got overflow=%b ready=%b expected overflow=1 ready=1", overflow, wr_ready);
    end
    tick();
  endtask

  task automatic test_order();
    rd_req = 1'b0;
    wr_req = 1'b1; wr_addr = 12'h000; wr_data = 8'h11;
    tick();
    wr_addr = 12'h001; wr_data = 8'h22;
    @(negedge clk_in);
    n_checks++;
    if ({mem_we, mem_be, mem_wdata, fifo_level} !== {1'b1, 2'b10, 16'h1100, 3'd1}) begin
      n_errors++;
      $display("FAIL order_first: got we=%b be=%b wdata=%h level=%0d expected we=1 be=10 wdata=1100 level=1",
               mem_we, mem_be, mem_wdata, fifo_level);
    end
    tick();
    wr_req = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if ({mem_we, mem_be, mem_wdata, fifo_level} !== {1'b1, 2'b01, 16'h0022, 3'd1}) begin
      n_errors++;
      $display("FAIL order_second: got we=%b be=%b wdata=%h level=%0d expected we=1 be=01 wdata=0022 level=1",
               mem_we, mem_be, mem_wdata, fifo_level);
    end
    tick();
    @(negedge clk_in);
    n_checks++;
    if (fifo_level !== 3'd0 || mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL order_empty: got level=%0d we=%b expected level=0 we=0", fifo_level, mem_we);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1; rd_addr = 11'h010;
    @(negedge clk_in);
    n_checks++;
    if (rd_grant !== 1'b1) begin
      n_errors++;
      $display("FAIL midread_grant: got %b expected 1", rd_grant);
    end
    tick();
    rd_req = 1'b0;
    reset  = 1'b1;
    rd_q.delete();
    wr_q.delete();
    #1;
    check_reset_values("reset_async");
    repeat (2) tick();
    check_reset_values("reset_held");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      n_checks++;
      if (rd_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL discarded_read: got rd_valid=%b expected 0", rd_valid);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 16'(i * 7 + 5);
    ram[11'h010] = 16'hBEEF;
    ram[11'h020] = 16'h1111;
    ram[11'h021] = 16'h2222;
    ram[11'h022] = 16'h3333;
    mem_rdata = 16'h0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    reset = 1'b1;

    test_reset();
    test_write_lane();
    test_read();
    test_back_to_back();
    test_starvation();
    test_overflow();
    test_order();
    test_reset_mid_read();

    n_checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got writes=%0d reads=%0d expected 0 0", wr_q.size(), rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_port_arbiter.md
Name: framebuffer_port_arbiter

Overview:
- Shares one single-port, 16-bit-wide framebuffer RAM between two requesters: the byte-wise writer (UART command/control path) and the 16-bit pixel reader (scan fetch path).
- Reads have priority. Writes are buffered in a small FIFO and drained in idle cycles.
- A starvation guard forces a write slot when writes are pending too long.
- Sits between control/fetch logic and the RAM, all on clk_in.

Parameters:
- ADDR_WIDTH, 12, writer byte-address width; RAM word address is ADDR_WIDTH-1 bits.
- FIFO_DEPTH_LOG2, 2, write FIFO depth = 2**FIFO_DEPTH_LOG2 entries (default 4).
- STARVE_LIMIT, 4, consecutive denied cycles with pending writes before a forced write slot.
- STARVE_WIDTH, 3, counter width; must hold STARVE_LIMIT.

Ports:
- clk_in  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high; clears all state.
- wr_req  input  1  write request; sampled when wr_ready=1.
- wr_addr  input  ADDR_WIDTH  byte address; bit0 selects the byte lane.
- wr_data  input  8  write byte.
- wr_ready  output  1  FIFO not full (registered).
- rd_req  input  1  read request; held until rd_grant.
- rd_addr  input  ADDR_WIDTH-1  word address.
- rd_grant  output  1  read issued to RAM this cycle (combinational).
- rd_valid  output  1  one-cycle strobe; rd_data valid.
- rd_data  output  16  registered read word.
- mem_addr  output  ADDR_WIDTH-1  RAM word address.
- mem_wdata  output  16  RAM write data.
- mem_be  output  2  byte enables {hi, lo}.
- mem_we  output  1  RAM write enable.
- mem_ce  output  1  RAM clock enable.
- mem_rdata  input  16  RAM read data, valid 1 cycle after a ce with we=0.
- fifo_level  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy.
- overflow  output  1  sticky: a wr_req arrived while wr_ready=0.
- writes_committed  output  8  wrapping count of RAM writes issued.

Behaviour:
- Reset (async): FIFO empty, fifo_level=0, wr_ready=1, overflow=0, writes_committed=0, starve counter=0, rd_valid=0, rd_data=0, rd_grant=0, mem_ce=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. An in-flight read is discarded (no rd_valid after reset).
- Push: wr_req && wr_ready writes {wr_addr, wr_data} into the FIFO.
  - wr_req with wr_ready=0 is dropped and sets overflow (cleared only by reset).
- wr_ready = (fifo_level != depth), registered from the next-state level.
- Per-cycle arbitration:
  - FORCE_WR: starve_cnt == STARVE_LIMIT and FIFO non-empty → issue a write; rd_grant=0.
  - READ: else if rd_req → rd_grant=1, mem_ce=1, mem_we=0, mem_addr=rd_addr.
  - WRITE: else if FIFO non-empty → pop the head; mem_ce=1, mem_we=1, mem_addr=head_addr[ADDR_WIDTH-1:1].
  - IDLE: otherwise mem_ce=0.
- Byte lanes:
  - head_addr[0]=0 → mem_be=2'b10, mem_wdata={data,8'h00}.
  - head_addr[0]=1 → mem_be=2'b01, mem_wdata={8'h00,data}.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no write issues, saturating at STARVE_LIMIT.
  - Clears on any write issue or when the FIFO is empty.
- Read latency: grant at cycle N; mem_rdata valid at N+1; rd_data registered and rd_valid=1 at N+2. Back-to-back grants yield back-to-back rd_valid.
- Simultaneous push and pop: level unchanged; entry order preserved (FIFO, pointers wrap modulo depth).
- Push into an empty FIFO is not poppable until the next cycle (no bypass).
- writes_committed increments on every issued write and wraps 255 → 0.
- mem_* outputs are combinational from the arbitration decision and registered FIFO head.

Test Plan:
- Reset then write 0x0A5 = 8'h3C with rd_req=0 → next cycle mem_we=1, mem_addr=0x052, mem_be=2'b01, mem_wdata=16'h003C; writes_committed=1.
- rd_req held high with rd_addr=0x010, mem_rdata=16'hBEEF returned → rd_grant same cycle; rd_valid=1 with rd_data=16'hBEEF exactly 2 cycles after grant.
- rd_req continuously high, one write pushed → write issues on the 5th cycle after it becomes poppable (STARVE_LIMIT=4); rd_grant=0 that cycle only.
- rd_req high, 5 wr_req pushes on consecutive cycles → fifo_level reaches 4, wr_ready=0; 5th byte dropped; overflow=1 and stays 1.
- Reads idle, pushes at 0x000/0x001 → two writes in order with mem_be 10 then 01; fifo_level returns to 0; push+pop in the same cycle leaves level unchanged.
- Assert reset one cycle after a read grant → no rd_valid follows; all outputs at reset values; wr_ready=1 while reset is held.
